// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encoding and a
//   helper that sizes the bit counter.
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Bit-counter width. Never below 1 so the counter is a legal vector.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   One-bit subtractor with borrow-in, built from two half subtractors and an
//   OR: first stage computes a - b, second subtracts the incoming borrow.
// Ports
//   a    in   minuend bit
//   b    in   subtrahend bit
//   bin  in   borrow in
//   d    out  difference bit (a ^ b ^ bin)
//   bout out  borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1;
   logic b1;
   logic b2;

   half_subtractor u_hs0 (
      .a    (a),
      .b    (b),
      .d    (d1),
      .bout (b1)
   );

   // Second stage borrows when (a ^ b) == 0 and a borrow is coming in.
   half_subtractor u_hs1 (
      .a    (d1),
      .b    (bin),
      .d    (d),
      .bout (b2)
   );

   // The two stages can never both borrow, so OR is the full borrow.
   assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// -----------------------------------------------------------------------------
// half_subtractor
//   One-bit subtractor without borrow-in: d = a - b, bout set when a < b.
// Ports
//   a    in   minuend bit
//   b    in   subtrahend bit
//   d    out  difference bit
//   bout out  borrow out
// -----------------------------------------------------------------------------
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   assign d    = a ^ b;
   assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), processed LSB
//   first over WIDTH clocks through a single full_subtractor and one borrow
//   flop. Start/busy/done handshake; back-to-back starts accepted from DONE.
// Parameters
//   WIDTH   operand/result width, >= 2
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   synchronous reset, active low
//   start   in   request, sampled only when not busy
//   a, b    in   operands, captured on the accepting edge
//   busy    out  high while shifting
//   done    out  one-cycle pulse, diff/borrow valid
//   diff    out  result, held until the next completion
//   borrow  out  final borrow, 1 iff a < b
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             last;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Holds the WIDTH-1 already computed bits; the final bit comes straight
   // from the cell on the completion edge.
   logic [WIDTH-2:0] d_sh;
   logic [WIDTH-2:0] d_sh_nxt;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             d;
   logic             bout;

   full_subtractor u_fsub (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (br),
      .d    (d),
      .bout (bout)
   );

   assign last = (cnt == CW'(WIDTH - 1));

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path leaves
   // a signal unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            // A start here is taken immediately, skipping IDLE.
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_SHIFT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Result bits enter at the top and move down one place per cycle.
   always_comb begin
      d_sh_nxt            = d_sh >> 1;
      d_sh_nxt[WIDTH-2]   = d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         d_sh   <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         borrow <= 1'b0;
      end else if (accept) begin
         a_sh <= a;
         b_sh <= b;
         br   <= 1'b0;
         cnt  <= '0;
      end else if (state == ST_SHIFT) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         d_sh <= d_sh_nxt;
         br   <= bout;
         cnt  <= cnt + CW'(1);
         if (last) begin
            diff   <= {d, d_sh};
            borrow <= bout;
         end
      end
   end

   // Decoded from the state flop only, never from start.
   assign busy = (state == ST_SHIFT);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed and random checks of serial_subtractor with WIDTH=8.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_diff;
   logic         exp_borrow;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete operation; inputs driven and outputs sampled on negedges.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input string tag);
      int lat;
      @(negedge clk);
      a = ta; b = tb_; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " held"}, {23'd0, borrow, diff}, {23'd0, exp_borrow, exp_diff});
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      exp_diff   = ta - tb_;
      exp_borrow = (ta < tb_);
      check({tag, " latency"}, 32'(lat), 32'd8);
      check({tag, " diff"}, 32'(diff), 32'(exp_diff));
      check({tag, " borrow"}, 32'(borrow), 32'(exp_borrow));
      check({tag, " busy@done"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({tag, " done pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int lat;
      int npulse;
      rst_n = 1'b0; start = 1'($urandom); a = W'($urandom); b = W'($urandom);
      exp_diff = '0; exp_borrow = 1'b0;

      // 1. reset with random inputs
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("reset", {20'd0, busy, done, borrow, 1'b0, diff}, 32'd0);
         start = 1'($urandom); a = W'($urandom); b = W'($urandom);
      end
      rst_n = 1'b1; start = 1'b0;
      @(negedge clk);
      check("idle after reset", {22'd0, busy, done, diff}, 32'd0);

      // 2-3. directed vectors
      do_op(8'd9,   8'd5,   "9-5");
      check("9-5 const", 32'(diff), 32'h04);
      do_op(8'd5,   8'd9,   "5-9");
      check("5-9 const", {23'd0, borrow, diff}, 32'h1FC);
      do_op(8'd0,   8'd1,   "0-1");
      check("0-1 const", {23'd0, borrow, diff}, 32'h1FF);
      do_op(8'hFF,  8'hFF,  "FF-FF");
      check("FF-FF const", {23'd0, borrow, diff}, 32'h000);

      // 4. start pulsed mid-SHIFT is ignored
      @(negedge clk);
      a = 8'd100; b = 8'd30; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      a = 8'd1; b = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      npulse = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) npulse++;
      end
      check("ignored start pulses", 32'(npulse), 32'd1);
      check("ignored start diff", {23'd0, borrow, diff}, 32'd70);
      exp_diff = 8'd70; exp_borrow = 1'b0;

      // 5. start held across DONE
      @(negedge clk);
      a = 8'd50; b = 8'd20; start = 1'b1;
      @(negedge clk);
      a = 8'd200; b = 8'd100;
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("b2b first latency", 32'(lat), 32'd8);
      check("b2b first diff", {23'd0, borrow, diff}, 32'd30);
      @(negedge clk);
      lat = 1;
      check("b2b no idle", 32'(busy), 32'd1);
      start = 1'b0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("b2b done spacing", 32'(lat), 32'd9);
      check("b2b second diff", {23'd0, borrow, diff}, 32'd100);
      exp_diff = 8'd100; exp_borrow = 1'b0;

      // 6. reset in the middle of SHIFT
      @(negedge clk);
      a = 8'd77; b = 8'd11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort outputs", {20'd0, busy, done, borrow, 1'b0, diff}, 32'd0);
      npulse = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) npulse++;
      end
      check("abort no done", 32'(npulse), 32'd0);
      exp_diff = '0; exp_borrow = 1'b0;
      do_op(8'd3, 8'd2, "3-2");
      check("3-2 const", {23'd0, borrow, diff}, 32'd1);

      // random pairs
      for (int i = 0; i < 1000; i++) begin
         do_op(W'($urandom), W'($urandom), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
